// File: rtl/array_mult_seq.sv
// Sequential shift-add multiplier: one partial product per cycle over WIDTH cycles.
// Signed operands are multiplied as magnitudes, and the sign is applied to the final sum.
module array_mult_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_mag, b_shift;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             neg;
  logic [CW-1:0]    count;
  logic [PW-1:0]    acc, acc_step;
  logic             accept, last_step;

  // The magnitude of the most negative value still fits in WIDTH unsigned bits.
  assign a_abs     = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_abs     = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign accept    = in_valid && in_ready;
  assign last_step = (state == RUN) && (count == CW'(WIDTH - 1));
  assign acc_step  = acc + (b_shift[0] ? (PW'(a_mag) << count) : '0);

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_mag   <= '0;
      b_shift <= '0;
      neg     <= 1'b0;
      count   <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_mag   <= a_abs;
            b_shift <= b_abs;
            neg     <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
            acc     <= '0;
            count   <= '0;
          end
        end
        RUN: begin
          acc     <= acc_step;
          b_shift <= b_shift >> 1;
          count   <= count + CW'(1);
          // A zero magnitude negates to zero, so no separate sign fix-up is needed.
          if (last_step) product <= neg ? (~acc_step + PW'(1)) : acc_step;
        end
        default: ;
      endcase
    end
  end

endmodule
